// File: rtl/program_loader_if.sv
// Byte-stream receive link plus program-memory write port of the program loader.
// The slave side is the loader; the master side feeds bytes and observes writes.
interface program_loader_if #(
  parameter int INS_WIDTH = 13,
  parameter int PM_AW     = 6
);
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 pm_we;
  logic [PM_AW-1:0]     pm_addr;
  logic [INS_WIDTH-1:0] pm_wdata;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  pm_we,
    input  pm_addr,
    input  pm_wdata
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output pm_we,
    output pm_addr,
    output pm_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Framed byte-stream program loader: packs byte pairs into instruction words,
// writes them to program memory, checks the frame and releases the core when valid.
module program_loader #(
  parameter int         INS_WIDTH = 13,
  parameter int         PM_DEPTH  = 64,
  parameter int         PM_AW     = 6,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  program_loader_if.slave   bus,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    HI    = 3'd2,
    LO    = 3'd3,
    WRITE = 3'd4,
    CSUM  = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_COUNT = 2'd1;
  localparam logic [1:0] ERR_HIGH  = 2'd2;
  localparam logic [1:0] ERR_CSUM  = 2'd3;

  state_t               state_reg;
  logic                 rx_ready_reg;
  logic                 pm_we_reg;
  logic [PM_AW-1:0]     pm_addr_reg;
  logic [INS_WIDTH-1:0] pm_wdata_reg;
  logic                 cpu_hold_reg;
  logic                 done_reg;
  logic                 err_reg;
  logic [1:0]           err_code_reg;
  logic [PM_AW-1:0]     index_reg;
  logic [PM_AW-1:0]     last_reg;
  logic [7:0]           csum_reg;
  logic [4:0]           hi_reg;

  logic accept;
  logic count_bad;

  assign accept    = bus.rx_valid && rx_ready_reg;
  assign count_bad = (bus.rx_data == 8'd0) || (int'(bus.rx_data) > PM_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      rx_ready_reg <= 1'b0;
      pm_we_reg    <= 1'b0;
      pm_addr_reg  <= '0;
      pm_wdata_reg <= '0;
      cpu_hold_reg <= 1'b1;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= ERR_NONE;
      index_reg    <= '0;
      last_reg     <= '0;
      csum_reg     <= '0;
      hi_reg       <= '0;
    end else begin
      // Ready everywhere except the single WRITE cycle; write strobe is a pulse.
      rx_ready_reg <= 1'b1;
      pm_we_reg    <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (accept && bus.rx_data == SYNC_BYTE) begin
            state_reg <= COUNT;
          end
        end

        COUNT: begin
          if (accept) begin
            if (count_bad) begin
              state_reg    <= ERR;
              err_reg      <= 1'b1;
              err_code_reg <= ERR_COUNT;
            end else begin
              // Keep N-1 so the last-word test is a plain equality on the index.
              last_reg  <= PM_AW'(bus.rx_data - 8'd1);
              csum_reg  <= bus.rx_data;
              index_reg <= '0;
              state_reg <= HI;
            end
          end
        end

        HI: begin
          if (accept) begin
            if (bus.rx_data[7:5] != 3'b000) begin
              state_reg    <= ERR;
              err_reg      <= 1'b1;
              err_code_reg <= ERR_HIGH;
            end else begin
              hi_reg    <= bus.rx_data[4:0];
              csum_reg  <= csum_reg ^ bus.rx_data;
              state_reg <= LO;
            end
          end
        end

        LO: begin
          if (accept) begin
            csum_reg     <= csum_reg ^ bus.rx_data;
            rx_ready_reg <= 1'b0;
            pm_we_reg    <= 1'b1;
            pm_addr_reg  <= index_reg;
            pm_wdata_reg <= INS_WIDTH'({hi_reg, bus.rx_data});
            state_reg    <= WRITE;
          end
        end

        WRITE: begin
          index_reg <= index_reg + 1'b1;
          state_reg <= (index_reg == last_reg) ? CSUM : HI;
        end

        CSUM: begin
          if (accept) begin
            if (bus.rx_data == csum_reg) begin
              state_reg    <= DONE;
              done_reg     <= 1'b1;
              cpu_hold_reg <= 1'b0;
            end else begin
              state_reg    <= ERR;
              err_reg      <= 1'b1;
              err_code_reg <= ERR_CSUM;
            end
          end
        end

        DONE, ERR: begin
          // A new sync restarts loading; anything else is line noise.
          if (accept && bus.rx_data == SYNC_BYTE) begin
            state_reg    <= COUNT;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            err_code_reg <= ERR_NONE;
            cpu_hold_reg <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.rx_ready = rx_ready_reg;
  assign bus.pm_we    = pm_we_reg;
  assign bus.pm_addr  = pm_addr_reg;
  assign bus.pm_wdata = pm_wdata_reg;
  assign cpu_hold     = cpu_hold_reg;
  assign done         = done_reg;
  assign err          = err_reg;
  assign err_code     = err_code_reg;

endmodule
